// File: rtl/tx_payload_buffer.sv
// Byte FIFO that collects payload and launches fixed-length packet requests
// to a MAC TX framer, then streams the buffered bytes while the framer samples them.
//
// state    | meaning
// S_IDLE   | waiting for threshold or flush with framer free
// S_REQ    | one-cycle start_tx pulse, length_tx already latched
// S_ACCEPT | waiting for the framer to raise busy
// S_STREAM | feeding length_tx bytes on payload cycles
// S_DRAIN  | waiting for the framer to release busy
module tx_payload_buffer #(
  parameter int THRESHOLD  = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  output logic                  start_tx,
  output logic [7:0]            length_tx,
  output logic [7:0]            data_tx,
  input  logic                  payload,
  input  logic                  busy,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [8:0]          THR9    = 9'(THRESHOLD);
  localparam logic [7:0]          THR8    = 8'(THRESHOLD);
  localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACCEPT, S_STREAM, S_DRAIN} state_t;

  state_t                r_state, w_next;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2:0]   r_wr_ptr, r_rd_ptr;
  logic [7:0]            r_length, r_sent, r_data;
  logic                  r_overflow, r_pend;
  logic                  w_full, w_empty, w_wr, w_rd, w_launch;
  logic [8:0]            w_level9;
  logic [7:0]            w_len;

  assign level     = r_wr_ptr - r_rd_ptr;
  assign w_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_wr      = wr_en && !w_full;
  assign w_level9  = 9'(level);
  // Below threshold the level is < 256, so its low byte is the whole count.
  assign w_len     = (w_level9 >= THR9) ? THR8 : w_level9[7:0];

  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign length_tx = r_length;
  assign data_tx   = r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    w_rd     = 1'b0;
    start_tx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!busy && ((w_level9 >= THR9) || ((flush || r_pend) && !w_empty))) begin
          w_launch = 1'b1;
          w_next   = S_REQ;
        end
      end
      S_REQ: begin
        start_tx = 1'b1;
        w_next   = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (busy) w_next = S_STREAM;
      end
      S_STREAM: begin
        if (r_sent == r_length) w_next = S_DRAIN;
        else if (payload && !w_empty) w_rd = 1'b1;
      end
      S_DRAIN: begin
        if (!busy) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_length   <= '0;
      r_sent     <= '0;
      r_data     <= '0;
      r_overflow <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (wr_en && w_full) r_overflow <= 1'b1;
      if (w_rd) begin
        r_data   <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_sent   <= r_sent + 8'd1;
      end
      if (w_launch) begin
        r_length <= w_len;
        r_sent   <= '0;
      end
      // A flush arriving while the framer is busy with other traffic is held.
      if (r_state == S_IDLE && busy && flush) r_pend <= 1'b1;
      else if (r_state == S_DRAIN && !busy)   r_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_tx_payload_buffer.sv
// Bench for tx_payload_buffer: three parameterisations share one stimulus bus;
// a byte queue per test predicts packet lengths, contents and FIFO level.
module tb_tx_payload_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, wr_en, flush, payload, busy;
  logic [7:0] wr_data;
  logic [2:0] st_v, full_v, empty_v, ovf_v;
  logic [7:0] len_v [3];
  logic [7:0] dat_v [3];
  logic [8:0] lvl0, lvl2;
  logic [4:0] lvl1;

  tx_payload_buffer u0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .start_tx(st_v[0]), .length_tx(len_v[0]), .data_tx(dat_v[0]), .payload(payload),
    .busy(busy), .level(lvl0), .full(full_v[0]), .empty(empty_v[0]), .overflow(ovf_v[0]));

  tx_payload_buffer #(.THRESHOLD(32), .DEPTH_LOG2(4)) u1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .start_tx(st_v[1]), .length_tx(len_v[1]), .data_tx(dat_v[1]), .payload(payload),
    .busy(busy), .level(lvl1), .full(full_v[1]), .empty(empty_v[1]), .overflow(ovf_v[1]));

  tx_payload_buffer #(.THRESHOLD(200), .DEPTH_LOG2(8)) u2 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .start_tx(st_v[2]), .length_tx(len_v[2]), .data_tx(dat_v[2]), .payload(payload),
    .busy(busy), .level(lvl2), .full(full_v[2]), .empty(empty_v[2]), .overflow(ovf_v[2]));

  int         checks = 0;
  int         errors = 0;
  int         sel, thr, depth;
  logic [7:0] mq[$];
  logic [7:0] exp_pkt[$];
  logic       movf;

  function automatic logic [8:0] obs_level();
    case (sel)
      0:       return lvl0;
      1:       return {4'b0, lvl1};
      default: return lvl2;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
    if (mq.size() < depth) mq.push_back(b);
    else                   movf = 1'b1;
  endtask

  task automatic do_reset(input int s);
    sel   = s;
    thr   = (s == 2) ? 200 : 32;
    depth = (s == 1) ? 16 : 256;
    reset_n = 1'b0; wr_en = 1'b0; flush = 1'b0; payload = 1'b0; busy = 1'b0; wr_data = '0;
    step();
    step();
    mq.delete();
    movf    = 1'b0;
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (st_v[sel]) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic quiet(input string tag, input int n);
    bit saw = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (st_v[sel]) saw = 1'b1;
    end
    chk(tag, 32'(saw), 32'd0);
  endtask

  // Framer model: accepts the request, samples payload bytes, optionally writes concurrently.
  task automatic packet(input string tag, input int extra, input bit wr_during, input bit rebusy);
    bit ok;
    int n;
    n = (mq.size() < thr) ? mq.size() : thr;
    exp_pkt.delete();
    for (int i = 0; i < n; i++) exp_pkt.push_back(mq.pop_front());
    wait_start(ok);
    chk({tag, "_start"}, 32'(ok), 32'd1);
    if (!ok) return;
    chk({tag, "_len"}, 32'(len_v[sel]), 32'(n));
    busy = 1'b1;
    step();
    chk({tag, "_pulse"}, 32'(st_v[sel]), 32'd0);
    step();
    payload = 1'b1;
    for (int i = 0; i < n + extra; i++) begin
      if (wr_during && ($urandom_range(0, 1) == 1)) wr(8'($urandom));
      else step();
      if (i < n) chk({tag, "_data"}, 32'(dat_v[sel]), 32'(exp_pkt[i]));
      else       chk({tag, "_hold"}, 32'(dat_v[sel]), 32'(exp_pkt[n-1]));
    end
    payload = 1'b0;
    busy    = 1'b0;
    step();
    if (rebusy) busy = 1'b1;
    chk({tag, "_lvl"}, 32'(obs_level()), 32'(mq.size()));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    bit f;
    int n;

    // Threshold launch of 32 sequential bytes
    do_reset(0);
    chk("rst_start", 32'(st_v[0]), 32'd0);
    chk("rst_len", 32'(len_v[0]), 32'd0);
    chk("rst_data", 32'(dat_v[0]), 32'd0);
    chk("rst_level", 32'(lvl0), 32'd0);
    chk("rst_empty", 32'(empty_v[0]), 32'd1);
    chk("rst_full", 32'(full_v[0]), 32'd0);
    chk("rst_ovf", 32'(ovf_v[0]), 32'd0);
    for (int i = 0; i < 32; i++) wr(8'(i));
    packet("thr32", 1, 1'b0, 1'b0);
    chk("thr32_empty", 32'(empty_v[0]), 32'd1);

    // Flush below threshold, payload held three extra cycles
    for (int i = 0; i < 5; i++) wr(8'(8'h40 + i));
    flush = 1'b1;
    step();
    flush = 1'b0;
    packet("flush5", 3, 1'b0, 1'b0);

    // Flush with nothing buffered must not launch
    flush = 1'b1;
    step();
    flush = 1'b0;
    quiet("flush_empty", 4);

    // Framer busy with ARP while 40 bytes arrive, then pending flush while busy
    busy = 1'b1;
    for (int i = 0; i < 40; i++) wr(8'(8'h80 + i));
    quiet("busy_hold", 3);
    chk("busy_lvl", 32'(lvl0), 32'd40);
    busy = 1'b0;
    packet("arp32", 1, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    quiet("pend_hold", 3);
    busy = 1'b0;
    packet("pend8", 2, 1'b0, 1'b0);

    // Reset asserted mid-stream
    for (int i = 0; i < 32; i++) wr(8'($urandom));
    wait_start(ok);
    chk("rms_start", 32'(ok), 32'd1);
    busy = 1'b1;
    step();
    step();
    payload = 1'b1;
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("rms_start0", 32'(st_v[0]), 32'd0);
    chk("rms_len", 32'(len_v[0]), 32'd0);
    chk("rms_data", 32'(dat_v[0]), 32'd0);
    chk("rms_level", 32'(lvl0), 32'd0);
    chk("rms_empty", 32'(empty_v[0]), 32'd1);
    busy = 1'b0;
    payload = 1'b0;
    mq.delete();
    step();
    reset_n = 1'b1;
    quiet("rms_idle", 5);
    chk("rms_lvl_after", 32'(lvl0), 32'd0);

    // 16-deep FIFO overflow
    do_reset(1);
    busy = 1'b1;
    for (int i = 1; i <= 20; i++) wr(8'(i));
    chk("ovf_full", 32'(full_v[1]), 32'd1);
    chk("ovf_level", 32'(lvl1), 32'd16);
    chk("ovf_flag", 32'(ovf_v[1]), 32'(movf));
    busy  = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    packet("ovf16", 1, 1'b0, 1'b0);
    chk("ovf_sticky", 32'(ovf_v[1]), 32'd1);
    chk("ovf_empty", 32'(empty_v[1]), 32'd1);

    // Three 200-byte packets crossing the pointer wrap
    do_reset(2);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 200; i++) wr(8'($urandom));
      packet("wrap200", 1, 1'b0, 1'b0);
    end

    // Randomized bursts with concurrent writes during streaming
    do_reset(0);
    busy = 1'b1;
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(0, 45);
      for (int i = 0; i < n; i++) wr(8'($urandom));
      f = 1'($urandom_range(0, 1));
      busy  = 1'b0;
      flush = f;
      step();
      flush = 1'b0;
      if (mq.size() >= thr || (f && mq.size() > 0)) begin
        packet("rnd", $urandom_range(1, 3), 1'b1, 1'b1);
      end else begin
        quiet("rnd_quiet", 3);
        busy = 1'b1;
      end
      chk("rnd_ovf", 32'(ovf_v[0]), 32'(movf));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
